// File: rtl/sd_cmd_sender.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sd_cmd_sender : serialises one 48-bit SD command frame onto the CMD line  |
// |                 using an external CRC7 generator.                         |
// | Option macro  : SD_CMD_CRC_TIMEOUT_EN (abort on missing CRC result)       |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module sd_cmd_sender #(
    parameter int GAP_BITS    = 8,
    parameter int CRC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        Clk_En,
    input  logic        Start,
    input  logic [5:0]  Cmd_Index,
    input  logic [31:0] Argument,
    output logic        CRC_Enable,
    output logic [47:0] CRC_Message,
    input  logic        CRC_Valid,
    input  logic [6:0]  CRC,
    output logic        CMD_Out,
    output logic        CMD_OE,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CRC_WAIT = 2'd1;
    localparam logic [1:0] S_SHIFT    = 2'd2;
    localparam logic [1:0] S_GAP      = 2'd3;

    localparam int GAP_W = (GAP_BITS < 1) ? 1 : $clog2(GAP_BITS + 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [5:0]       r_cmd_index;
    logic [31:0]      r_argument;
    logic [47:0]      r_shift;
    logic [5:0]       r_bit_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_first;

    logic             w_accept;
    logic             w_timeout;
    logic             w_last_bit;
    logic             w_release;

    logic             w_crc_en_nxt;
    logic [47:0]      w_crc_msg_nxt;
    logic             w_cmd_out_nxt;
    logic             w_cmd_oe_nxt;

    // The CRC generator may still present the previous command's result in
    // the first wait cycle, so acceptance is held off until r_first clears.
    assign w_accept   = (r_state == S_CRC_WAIT) && !r_first && CRC_Valid;
    assign w_last_bit = (r_state == S_SHIFT) && Clk_En && (r_bit_cnt == 6'd47);
    assign w_release  = (r_state == S_GAP) && Clk_En && (r_gap_cnt == GAP_W'(GAP_BITS));

`ifdef SD_CMD_CRC_TIMEOUT_EN
    localparam int TMO_W = (CRC_TIMEOUT < 2) ? 1 : $clog2(CRC_TIMEOUT);

    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_timeout = (r_state == S_CRC_WAIT) && !w_accept &&
                       (r_tmo_cnt == TMO_W'(CRC_TIMEOUT - 1));

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_tmo_cnt <= '0;
            Error     <= 1'b0;
        end else begin
            Error <= w_timeout;
            if (r_state == S_CRC_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign Error     = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start) w_state_nxt = S_CRC_WAIT;
            end
            S_CRC_WAIT: begin
                if (w_accept)       w_state_nxt = S_SHIFT;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_SHIFT: begin
                if (w_last_bit) w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (w_release) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs
    always_comb begin
        w_crc_en_nxt  = CRC_Enable;
        w_crc_msg_nxt = CRC_Message;
        w_cmd_out_nxt = CMD_Out;
        w_cmd_oe_nxt  = CMD_OE;
        case (r_state)
            S_IDLE: begin
                w_cmd_out_nxt = 1'b1;
                w_cmd_oe_nxt  = 1'b0;
                if (Start) begin
                    w_crc_en_nxt  = 1'b1;
                    w_crc_msg_nxt = {2'b01, Cmd_Index, Argument, 8'h01};
                end
            end
            S_CRC_WAIT: begin
                if (w_accept || w_timeout) w_crc_en_nxt = 1'b0;
            end
            S_SHIFT: begin
                if (Clk_En) begin
                    w_cmd_out_nxt = r_shift[47];
                    w_cmd_oe_nxt  = 1'b1;
                end
            end
            S_GAP: begin
                if (Clk_En) begin
                    w_cmd_out_nxt = 1'b1;
                    w_cmd_oe_nxt  = !w_release;
                end
            end
            default: begin
                w_cmd_out_nxt = 1'b1;
                w_cmd_oe_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            CMD_Out     <= 1'b1;
            CMD_OE      <= 1'b0;
            CRC_Enable  <= 1'b0;
            CRC_Message <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            r_cmd_index <= '0;
            r_argument  <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_first     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            CMD_Out     <= w_cmd_out_nxt;
            CMD_OE      <= w_cmd_oe_nxt;
            CRC_Enable  <= w_crc_en_nxt;
            CRC_Message <= w_crc_msg_nxt;
            Busy        <= (w_state_nxt != S_IDLE);
            Done        <= w_release;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_cmd_index <= Cmd_Index;
                        r_argument  <= Argument;
                        r_first     <= 1'b1;
                    end
                end
                S_CRC_WAIT: begin
                    r_first <= 1'b0;
                    if (w_accept) begin
                        r_shift   <= {2'b01, r_cmd_index, r_argument, CRC, 1'b1};
                        r_bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (Clk_En) begin
                        r_shift   <= {r_shift[46:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                        r_gap_cnt <= '0;
                    end
                end
                S_GAP: begin
                    if (Clk_En && !w_release) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/sd_cmd_sender.md
SD_CMD_SENDER -- requirements
Module: sd_cmd_sender

Interface
REQ-001 SHALL have parameter GAP_BITS, default 8: number of high bits driven after the end bit before release.
REQ-002 SHALL have parameter CRC_TIMEOUT, default 64: maximum clk cycles spent waiting for CRC_Valid.
REQ-003 SHALL have port clk  input  1  system clock; all state advances on the rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Clk_En  input  1  SD bit-rate strobe; one CMD bit per strobe.
REQ-006 SHALL have port Start  input  1  request to send one command; sampled only in IDLE.
REQ-007 SHALL have port Cmd_Index  input  6  command index.
REQ-008 SHALL have port Argument  input  32  command argument.
REQ-009 SHALL have port CRC_Enable  output  1  enable to the CRC7 generator.
REQ-010 SHALL have port CRC_Message  output  48  message to the CRC7 generator.
REQ-011 SHALL have port CRC_Valid  input  1  CRC7 generator result valid.
REQ-012 SHALL have port CRC  input  7  CRC7 generator result.
REQ-013 SHALL have port CMD_Out  output  1  serial SD CMD line data.
REQ-014 SHALL have port CMD_OE  output  1  CMD line output enable.
REQ-015 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port Done  output  1  one-cycle pulse when the command completes.
REQ-017 SHALL have port Error  output  1  one-cycle pulse when a CRC timeout aborts the command.

Function
REQ-018 SHALL implement the states IDLE, CRC_WAIT, SHIFT and GAP; all outputs SHALL be registered.
REQ-019 In IDLE with Start=1, SHALL latch Cmd_Index and Argument and enter CRC_WAIT on the next edge; Start SHALL be ignored in all other states.
REQ-020 In CRC_WAIT, SHALL hold CRC_Enable=1 and CRC_Message={1'b0,1'b1,Cmd_Index,Argument,8'h01}, with the latched values held stable.
REQ-021 SHALL ignore CRC_Valid during the first CRC_WAIT cycle, so a stale CRC result is never accepted.
REQ-022 On CRC_Valid=1 from the second CRC_WAIT cycle onward, SHALL load the 48-bit frame {0,1,Cmd_Index,Argument,CRC,1} into the shift register, drop CRC_Enable and enter SHIFT.
REQ-023 In SHIFT, on each Clk_En, SHALL drive the frame MSB onto CMD_Out, shift the register left and increment a 6-bit counter, with CMD_OE=1 throughout.
REQ-024 After the 48th bit has been driven, SHALL enter GAP; that bit SHALL remain on CMD_Out until the next Clk_En.
REQ-025 In GAP, on each Clk_En, SHALL drive CMD_Out=1 with CMD_OE=1.
REQ-026 After GAP_BITS strobes in GAP, SHALL set CMD_OE=0, pulse Done for one clk and return to IDLE.
REQ-027 Clk_En=0 SHALL freeze SHIFT and GAP with no bit change; Clk_En SHALL have no effect in IDLE or CRC_WAIT.
REQ-028 CMD_Out SHALL be 1 whenever CMD_OE=0.

Reset
REQ-029 Reset_n=0 SHALL asynchronously force IDLE, CMD_Out=1, CMD_OE=0, CRC_Enable=0, CRC_Message=0, Busy=0, Done=0, Error=0 and clear all counters, including when asserted mid-frame.
REQ-030 After Reset_n deasserts, the first Start SHALL be accepted on the first rising edge.

Configuration
REQ-031 With SD_CMD_CRC_TIMEOUT_EN defined, CRC_WAIT SHALL count clk cycles, and on reaching CRC_TIMEOUT without CRC_Valid SHALL drop CRC_Enable, pulse Error for one clk and return to IDLE with CMD_OE never asserted.
REQ-032 Without SD_CMD_CRC_TIMEOUT_EN, CRC_WAIT SHALL wait indefinitely and Error SHALL be tied to 0.

Verification
REQ-033 Bench SHALL cover: CMD0, Argument=0, Clk_En always 1 -> CMD_Out bits = 0x40 00 00 00 00 95, then 8 ones, Done pulse.
REQ-034 Bench SHALL cover: CMD8, Argument=0x000001AA -> frame 0x48 00 00 01 AA 87, with CRC_Message[47:8]=0x48000001AA.
REQ-035 Bench SHALL cover: Clk_En every 4th clk -> each frame bit held exactly 4 clk, total 56 strobes from the first bit to release.
REQ-036 Bench SHALL cover: Start re-pulsed while Busy=1 -> ignored, a single frame only, latched values unchanged.
REQ-037 Bench SHALL cover: with the macro defined and CRC_Valid tied to 0 -> Error pulse 64 clk after entering CRC_WAIT, CMD_OE stays 0, Busy=0.
REQ-038 Bench SHALL cover: Reset_n pulsed low at bit 20 of SHIFT -> CMD_OE=0 and CMD_Out=1 immediately, then a following CMD0 frame is correct.
